// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, opcode classes and pipeline latency defaults.
// Used by both the hazard controller and the datapath.
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam int WB_LAT_DEF = 3;

    typedef enum logic [2:0] {
        CLS_RR,
        CLS_RI,
        CLS_SW,
        CLS_BR,
        CLS_HLT,
        CLS_NOP
    } op_class_e;

    // LW shares the RI register usage pattern (src rs, dst rt)
    function automatic op_class_e op_class(input logic [5:0] opcode);
        op_class_e cls;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = CLS_RR;
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW:              cls = CLS_RI;
            OP_SW:                                         cls = CLS_SW;
            OP_BNEQZ, OP_BEQZ:                             cls = CLS_BR;
            OP_HLT:                                        cls = CLS_HLT;
            default:                                       cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mips32_dep_decode.sv
// Register-dependency decode of the instruction in ID: which registers it reads and writes.
module mips32_dep_decode
    import mips32_pkg::*;
(
    input  logic [31:0] id_instr,
    output logic        src1_vld,
    output logic [4:0]  src1_idx,
    output logic        src2_vld,
    output logic [4:0]  src2_idx,
    output logic        dst_vld,
    output logic [4:0]  dst_idx,
    output logic        is_hlt
);

    op_class_e cls_s;

    assign cls_s = op_class(id_instr[31:26]);

    // Map opcode class to source/destination register usage
    always_comb begin
        src1_vld = 1'b0;
        src1_idx = id_instr[25:21];
        src2_vld = 1'b0;
        src2_idx = id_instr[20:16];
        dst_vld  = 1'b0;
        dst_idx  = 5'd0;
        is_hlt   = 1'b0;
        case (cls_s)
            CLS_RR: begin
                src1_vld = 1'b1;
                src2_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_idx  = id_instr[15:11];
            end
            CLS_RI: begin
                src1_vld = 1'b1;
                dst_vld  = 1'b1;
                dst_idx  = id_instr[20:16];
            end
            CLS_SW: begin
                src1_vld = 1'b1;
                src2_vld = 1'b1;
            end
            CLS_BR: begin
                src1_vld = 1'b1;
            end
            CLS_HLT: begin
                is_hlt = 1'b1;
            end
            default: begin
                is_hlt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Scoreboard-based pipeline controller: RAW stalls, taken-branch flush and HLT drain/halt sequencing.
module mips32_hazard_ctrl
    import mips32_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int SB_W = $clog2(WB_LAT + 1);
    localparam logic [SB_W-1:0] SB_LOAD = SB_W'(WB_LAT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e            state_r;
    state_e            state_next_s;
    logic [SB_W-1:0]   sb_cnt_r [1:31];
    logic [31:0]       busy_mask_s;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              halted_r;

    logic              src1_vld_s;
    logic [4:0]        src1_idx_s;
    logic              src2_vld_s;
    logic [4:0]        src2_idx_s;
    logic              dst_vld_s;
    logic [4:0]        dst_idx_s;
    logic              is_hlt_s;
    logic              hazard_s;
    logic              issue_s;
    logic              stall_inc_s;

    mips32_dep_decode u_dep_decode (
        .id_instr (id_instr),
        .src1_vld (src1_vld_s),
        .src1_idx (src1_idx_s),
        .src2_vld (src2_vld_s),
        .src2_idx (src2_idx_s),
        .dst_vld  (dst_vld_s),
        .dst_idx  (dst_idx_s),
        .is_hlt   (is_hlt_s)
    );

    // Busy view of the scoreboard; R0 is hardwired idle so it never causes a stall
    always_comb begin
        busy_mask_s = 32'd0;
        for (int r = 1; r < 32; r++) begin
            busy_mask_s[r] = (sb_cnt_r[r] != SB_W'(0));
        end
    end

    assign hazard_s = id_valid &
                      ((src1_vld_s & busy_mask_s[src1_idx_s]) |
                       (src2_vld_s & busy_mask_s[src2_idx_s]));

    // FSM next state and same-cycle pipeline control
    always_comb begin
        state_next_s = state_r;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b1;
        issue_s      = 1'b0;
        stall_inc_s  = 1'b0;
        if (!rst_n) begin
            ifid_flush   = 1'b1;
            state_next_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (ex_br_taken) begin
                        ifid_flush = 1'b1;
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                    end else if (hazard_s) begin
                        stall_inc_s = 1'b1;
                    end else if (id_valid && is_hlt_s) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        idex_bubble = 1'b0;
                        issue_s     = id_valid;
                    end
                end
                ST_DRAIN: begin
                    if (busy_mask_s == 32'd0) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    state_next_s = ST_HALT;
                end
                default: begin
                    state_next_s = ST_RUN;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Scoreboard countdown; a fresh issue to the same register wins over the decrement
    always_ff @(posedge clk1) begin
        for (int r = 1; r < 32; r++) begin
            if (!rst_n) begin
                sb_cnt_r[r] <= SB_W'(0);
            end else if (issue_s && dst_vld_s && (dst_idx_s == 5'(r))) begin
                sb_cnt_r[r] <= SB_LOAD;
            end else if (sb_cnt_r[r] != SB_W'(0)) begin
                sb_cnt_r[r] <= sb_cnt_r[r] - SB_W'(1);
            end else begin
                sb_cnt_r[r] <= sb_cnt_r[r];
            end
        end
    end

    // Saturating RAW-stall statistics counter
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Sticky halt flag, raised together with entry into HALT
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= halted_r | (state_next_s == ST_HALT);
        end
    end

    assign halted    = halted_r;
    assign busy_mask = busy_mask_s;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Directed self-checking bench for mips32_hazard_ctrl.
module tb_mips32_hazard_ctrl;

    logic        clk1;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_br_taken;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [31:0] busy_mask;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    mips32_hazard_ctrl #(.WB_LAT(3), .CNT_W(16)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .ex_br_taken (ex_br_taken),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .halted      (halted),
        .busy_mask   (busy_mask),
        .stall_cnt   (stall_cnt)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic cyc();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        id_valid    = 1'b0;
        id_instr    = 32'h0;
        ex_br_taken = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        id_valid    = 1'b1;
        id_instr    = 32'h2801000a;
        ex_br_taken = 1'b0;
        cyc();
        cyc();
        checks++;
        if (pc_en !== 1'b0 || ifid_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_pc_en: pc_en=%b ifid_en=%b expected 0 0", pc_en, ifid_en);
        end
        checks++;
        if (idex_bubble !== 1'b1 || ifid_flush !== 1'b1) begin
            failures++;
            $display("FAIL reset_flush: bubble=%b flush=%b expected 1 1", idex_bubble, ifid_flush);
        end
        checks++;
        if (busy_mask !== 32'h0 || halted !== 1'b0 || stall_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: busy=%h halted=%b stall=%0d expected 0 0 0", busy_mask, halted, stall_cnt);
        end
        rst_n    = 1'b1;
        id_valid = 1'b0;
        #1;
    endtask

    task automatic test_raw_stall();
        do_reset();
        id_valid = 1'b1;
        id_instr = 32'h2801000a;
        #1;
        checks++;
        if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
            failures++;
            $display("FAIL raw_first_issue: pc_en=%b bubble=%b expected 1 0", pc_en, idex_bubble);
        end
        cyc();
        id_instr = 32'h00222000;
        #1;
        checks++;
        if (busy_mask !== 32'h2) begin
            failures++;
            $display("FAIL raw_busy_r1: busy=%h expected 00000002", busy_mask);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_bubble !== 1'b1) begin
                failures++;
                $display("FAIL raw_stall_%0d: pc_en=%b ifid_en=%b bubble=%b expected 0 0 1", i, pc_en, ifid_en, idex_bubble);
            end
            cyc();
        end
        checks++;
        if (pc_en !== 1'b1 || idex_bubble !== 1'b0 || stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL raw_release: pc_en=%b bubble=%b stall=%0d expected 1 0 3", pc_en, idex_bubble, stall_cnt);
        end
        cyc();
        id_valid = 1'b0;
        #1;
        checks++;
        if (busy_mask !== 32'h10) begin
            failures++;
            $display("FAIL raw_busy_r4: busy=%h expected 00000010", busy_mask);
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        id_valid = 1'b1;
        id_instr = 32'h2801000a;
        cyc();
        id_instr = 32'h28020014;
        #1;
        checks++;
        if (pc_en !== 1'b1 || busy_mask !== 32'h2) begin
            failures++;
            $display("FAIL nostall_indep: pc_en=%b busy=%h expected 1 00000002", pc_en, busy_mask);
        end
        cyc();
        id_valid = 1'b0;
        #1;
        checks++;
        if (busy_mask !== 32'h6 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL nostall_busy: busy=%h stall=%0d expected 00000006 0", busy_mask, stall_cnt);
        end
    endtask

    task automatic test_r0();
        do_reset();
        id_valid = 1'b1;
        id_instr = 32'h28000005;
        cyc();
        id_instr = 32'h00002000;
        #1;
        checks++;
        if (pc_en !== 1'b1 || busy_mask !== 32'h0) begin
            failures++;
            $display("FAIL r0_untracked: pc_en=%b busy=%h expected 1 00000000", pc_en, busy_mask);
        end
        cyc();
        id_valid = 1'b0;
        #1;
        checks++;
        if (busy_mask !== 32'h10) begin
            failures++;
            $display("FAIL r0_busy_r4: busy=%h expected 00000010", busy_mask);
        end
    endtask

    task automatic test_branch_hlt();
        do_reset();
        id_valid    = 1'b1;
        id_instr    = 32'hfc000000;
        ex_br_taken = 1'b1;
        #1;
        checks++;
        if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1 || pc_en !== 1'b1 || ifid_en !== 1'b1) begin
            failures++;
            $display("FAIL br_flush: flush=%b bubble=%b pc_en=%b ifid_en=%b expected 1 1 1 1", ifid_flush, idex_bubble, pc_en, ifid_en);
        end
        cyc();
        ex_br_taken = 1'b0;
        id_instr    = 32'h28030007;
        #1;
        checks++;
        if (halted !== 1'b0 || pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
            failures++;
            $display("FAIL br_stay_run: halted=%b pc_en=%b bubble=%b expected 0 1 0", halted, pc_en, idex_bubble);
        end
        cyc();
        id_valid = 1'b0;
        #1;
        checks++;
        if (busy_mask !== 32'h8) begin
            failures++;
            $display("FAIL br_issue_after: busy=%h expected 00000008", busy_mask);
        end
    endtask

    task automatic test_halt();
        int n;
        do_reset();
        id_valid = 1'b1;
        id_instr = 32'h2801000a;
        cyc();
        id_instr = 32'hfc000000;
        #1;
        checks++;
        if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_bubble !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL hlt_seen: pc_en=%b ifid_en=%b bubble=%b halted=%b expected 0 0 1 0", pc_en, ifid_en, idex_bubble, halted);
        end
        cyc();
        id_instr    = 32'h28050001;
        ex_br_taken = 1'b1;
        #1;
        checks++;
        if (pc_en !== 1'b0 || ifid_flush !== 1'b0 || idex_bubble !== 1'b1 || busy_mask !== 32'h2) begin
            failures++;
            $display("FAIL drain_ignore: pc_en=%b flush=%b bubble=%b busy=%h expected 0 0 1 00000002", pc_en, ifid_flush, idex_bubble, busy_mask);
        end
        n = 0;
        while (halted !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        checks++;
        if (n !== 3) begin
            failures++;
            $display("FAIL halt_latency: cycles=%0d expected 3", n);
        end
        checks++;
        if (halted !== 1'b1 || busy_mask !== 32'h0) begin
            failures++;
            $display("FAIL halt_reached: halted=%b busy=%h expected 1 00000000", halted, busy_mask);
        end
        for (int i = 0; i < 3; i++) begin
            id_instr    = 32'h00222000 + 32'(i);
            ex_br_taken = i[0];
            cyc();
            checks++;
            if (halted !== 1'b1 || pc_en !== 1'b0 || busy_mask !== 32'h0) begin
                failures++;
                $display("FAIL halt_sticky_%0d: halted=%b pc_en=%b busy=%h expected 1 0 00000000", i, halted, pc_en, busy_mask);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc_en !== 1'b0 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1) begin
            failures++;
            $display("FAIL halt_rst_force: pc_en=%b flush=%b bubble=%b expected 0 1 1", pc_en, ifid_flush, idex_bubble);
        end
        cyc();
        rst_n       = 1'b1;
        id_valid    = 1'b0;
        ex_br_taken = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || busy_mask !== 32'h0 || pc_en !== 1'b1) begin
            failures++;
            $display("FAIL halt_cleared: halted=%b busy=%h pc_en=%b expected 0 00000000 1", halted, busy_mask, pc_en);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        id_valid    = 1'b0;
        id_instr    = 32'h0;
        ex_br_taken = 1'b0;
        test_reset();
        test_raw_stall();
        test_no_stall();
        test_r0();
        test_branch_hlt();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
